day_night_sched: RTL and testbench

- Schedules the day/night cycle for the game renderer.
- Converts a night-trigger pulse from score logic into a night_rate envelope: fade in, hold, fade out.
- night_rate drives the night sprite block, which activates when night_rate > 32.
- Generates and latches per-night star placement random values using an internal LFSR.
- Sits between score/game-state logic and the night sprite block. Advances on the per-frame update strobe.

---
 rtl/day_night_sched_if.sv | 21 ++
 rtl/day_night_sched.sv | 137 +++++++++++++
 tb/tb_day_night_sched.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/day_night_sched_if.sv
// Game-side control strobes in, night envelope and star placement out.
interface day_night_sched_if;
   logic       update;
   logic       crash;
   logic       restart;
   logic       night_trigger;
   logic [5:0] night_rate;
   logic       in_night;
   logic [9:0] star_x_rand [2];
   logic [9:0] star_y_rand [2];

   modport master (
      output update, crash, restart, night_trigger,
      input  night_rate, in_night, star_x_rand, star_y_rand
   );

   modport slave (
      input  update, crash, restart, night_trigger,
      output night_rate, in_night, star_x_rand, star_y_rand
   );
endinterface

// File: rtl/day_night_sched.sv
// Day/night envelope (fade in, hold, fade out) with per-night star latch from a free-running LFSR.
// All outputs registered: visible the cycle after a qualifying update; no backpressure.
module day_night_sched #(
   parameter int          FADE_STEP    = 2,
   parameter int          NIGHT_FRAMES = 720,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input logic clk,
   input logic rst,
   day_night_sched_if.slave bus
);

   typedef enum logic [1:0] {DAY, FADE_IN, HOLD, FADE_OUT} state_t;

   localparam logic [5:0] STEP      = 6'(FADE_STEP);
   localparam logic [9:0] HOLD_LAST = 10'(NIGHT_FRAMES - 1);

   state_t      state, state_n;
   logic [5:0]  rate, rate_n;
   logic [9:0]  hold_cnt, hold_n;
   logic        pending, pending_n;
   logic        in_night;
   logic [15:0] lfsr;
   logic [9:0]  sx [2];
   logic [9:0]  sy [2];
   logic [9:0]  sx_n [2];
   logic [9:0]  sy_n [2];
   logic        q;
   logic [6:0]  sum7;
   logic [6:0]  diff7;

   function automatic logic [9:0] fold(input logic [8:0] v);
      return (v >= 9'd320) ? {1'b0, v - 9'd320} : {1'b0, v};
   endfunction

   assign q     = bus.update & ~bus.crash & ~bus.restart;
   assign sum7  = {1'b0, rate} + {1'b0, STEP};
   assign diff7 = {1'b0, rate} - {1'b0, STEP};

   always_comb begin
      state_n   = state;
      rate_n    = rate;
      hold_n    = hold_cnt;
      pending_n = pending;
      sx_n[0]   = sx[0];
      sx_n[1]   = sx[1];
      sy_n[0]   = sy[0];
      sy_n[1]   = sy[1];
      if (bus.restart) begin
         state_n   = DAY;
         rate_n    = 6'd0;
         hold_n    = 10'd0;
         pending_n = 1'b0;
      end else begin
         // Triggers only count in DAY; a same-cycle q consumes them below.
         if (state == DAY && bus.night_trigger)
            pending_n = 1'b1;
         if (q) begin
            case (state)
               DAY: begin
                  if (pending || bus.night_trigger) begin
                     state_n   = FADE_IN;
                     pending_n = 1'b0;
                     rate_n    = STEP;
                     sx_n[0]   = fold(lfsr[8:0]);
                     sx_n[1]   = fold(lfsr[15:7]);
                     sy_n[0]   = {4'b0, lfsr[5:0]};
                     sy_n[1]   = {4'b0, lfsr[11:6]};
                  end
               end
               FADE_IN: begin
                  if (sum7 >= 7'd63) begin
                     rate_n  = 6'd63;
                     state_n = HOLD;
                     hold_n  = 10'd0;
                  end else begin
                     rate_n = sum7[5:0];
                  end
               end
               HOLD: begin
                  rate_n = 6'd63;
                  if (hold_cnt == HOLD_LAST) begin
                     state_n = FADE_OUT;
                     rate_n  = 6'd63 - STEP;
                  end else begin
                     hold_n = hold_cnt + 10'd1;
                  end
               end
               FADE_OUT: begin
                  // Borrow (bit 6) or exact zero both land on day.
                  if (diff7[6] || diff7 == 7'd0) begin
                     rate_n  = 6'd0;
                     state_n = DAY;
                  end else begin
                     rate_n = diff7[5:0];
                  end
               end
               default: state_n = DAY;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= DAY;
         rate     <= 6'd0;
         hold_cnt <= 10'd0;
         pending  <= 1'b0;
         in_night <= 1'b0;
         lfsr     <= LFSR_SEED;
         sx[0]    <= 10'd0;
         sx[1]    <= 10'd0;
         sy[0]    <= 10'd0;
         sy[1]    <= 10'd0;
      end else begin
         state    <= state_n;
         rate     <= rate_n;
         hold_cnt <= hold_n;
         pending  <= pending_n;
         in_night <= (state_n != DAY);
         lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         sx[0]    <= sx_n[0];
         sx[1]    <= sx_n[1];
         sy[0]    <= sy_n[0];
         sy[1]    <= sy_n[1];
      end
   end

   assign bus.night_rate     = rate;
   assign bus.in_night       = in_night;
   assign bus.star_x_rand[0] = sx[0];
   assign bus.star_x_rand[1] = sx[1];
   assign bus.star_y_rand[0] = sy[0];
   assign bus.star_y_rand[1] = sy[1];

endmodule

// File: tb/tb_day_night_sched.sv
// Scoreboard bench for day_night_sched: reference model pushes expectations, DUT outputs pop and compare.
module tb_day_night_sched;
   localparam int          STEP = 2;
   localparam int          NF   = 720;
   localparam logic [15:0] SEED = 16'hACE1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   day_night_sched_if bus();

   day_night_sched #(.FADE_STEP(STEP), .NIGHT_FRAMES(NF), .LFSR_SEED(SEED)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [5:0]  rate;
      logic        night;
      logic [39:0] stars;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: 0 day, 1 fade in, 2 hold, 3 fade out
   int          m_st, m_rate, m_hold, m_sx0, m_sx1, m_sy0, m_sy1;
   bit          m_pend;
   logic [15:0] m_lfsr;

   always @(posedge clk or negedge rst) begin
      if (!rst) m_lfsr <= SEED;
      else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int fold(input int v);
      return (v >= 320) ? v - 320 : v;
   endfunction

   function automatic logic [39:0] model_stars();
      return {10'(m_sx0), 10'(m_sx1), 10'(m_sy0), 10'(m_sy1)};
   endfunction

   function automatic logic [39:0] dut_stars();
      return {bus.star_x_rand[0], bus.star_x_rand[1], bus.star_y_rand[0], bus.star_y_rand[1]};
   endfunction

   task automatic model_reset();
      m_st = 0; m_rate = 0; m_hold = 0; m_pend = 0;
      m_sx0 = 0; m_sx1 = 0; m_sy0 = 0; m_sy1 = 0;
   endtask

   task automatic model_step(input bit u, input bit c, input bit r, input bit t);
      bit q;
      q = u && !c && !r;
      if (r) begin
         m_st = 0; m_rate = 0; m_pend = 0; m_hold = 0;
      end else if (m_st == 0) begin
         if (q && (m_pend || t)) begin
            m_st = 1; m_pend = 0; m_rate = STEP;
            m_sx0 = fold(int'(m_lfsr[8:0]));
            m_sx1 = fold(int'(m_lfsr[15:7]));
            m_sy0 = int'(m_lfsr[5:0]);
            m_sy1 = int'(m_lfsr[11:6]);
         end else if (t) begin
            m_pend = 1;
         end
      end else if (q) begin
         if (m_st == 1) begin
            m_rate = m_rate + STEP;
            if (m_rate >= 63) begin m_rate = 63; m_st = 2; m_hold = 0; end
         end else if (m_st == 2) begin
            if (m_hold == NF - 1) begin m_st = 3; m_rate = 63 - STEP; end
            else m_hold++;
         end else begin
            if (m_rate - STEP <= 0) begin m_rate = 0; m_st = 0; end
            else m_rate = m_rate - STEP;
         end
      end
   endtask

   task automatic cycle(input bit u, input bit c, input bit r, input bit t);
      exp_t e;
      @(negedge clk);
      bus.update = u; bus.crash = c; bus.restart = r; bus.night_trigger = t;
      model_step(u, c, r, t);
      e.rate  = 6'(m_rate);
      e.night = (m_st != 0);
      e.stars = model_stars();
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("rate", 64'(bus.night_rate), 64'(e.rate));
      check("in_night", 64'(bus.in_night), 64'(e.night));
      check("stars", 64'(dut_stars()), 64'(e.stars));
   endtask

   task automatic qs(input int n);
      for (int i = 0; i < n; i++) cycle(1, 0, 0, 0);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst = 1'b0;
      bus.update = 0; bus.crash = 0; bus.restart = 0; bus.night_trigger = 0;
      #1;
      check("async_rate", 64'(bus.night_rate), 64'd0);
      check("async_night", 64'(bus.in_night), 64'd0);
      check("async_stars", 64'(dut_stars()), 64'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] saved;
      int          n;
      bus.update = 0; bus.crash = 0; bus.restart = 0; bus.night_trigger = 0;
      model_reset();
      #1;
      check("reset_rate", 64'(bus.night_rate), 64'd0);
      check("reset_night", 64'(bus.in_night), 64'd0);
      check("reset_stars", 64'(dut_stars()), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Idle updates in day
      qs(5);
      check("idle_rate", 64'(bus.night_rate), 64'd0);

      // Full night envelope
      cycle(0, 0, 0, 1);
      cycle(1, 0, 0, 0);
      check("q1_rate", 64'(bus.night_rate), 64'd2);
      check("q1_night", 64'(bus.in_night), 64'd1);
      qs(16);
      check("q17_rate", 64'(bus.night_rate), 64'd34);
      qs(15);
      check("q32_rate", 64'(bus.night_rate), 64'd63);
      qs(NF - 1);
      check("hold_end_rate", 64'(bus.night_rate), 64'd63);
      cycle(1, 0, 0, 0);
      check("fade_out_start", 64'(bus.night_rate), 64'd61);
      qs(30);
      check("fade_out_one", 64'(bus.night_rate), 64'd1);
      cycle(1, 0, 0, 0);
      check("day_rate", 64'(bus.night_rate), 64'd0);
      check("day_night", 64'(bus.in_night), 64'd0);

      // Crash freeze during fade in
      cycle(0, 0, 0, 1);
      qs(20);
      check("pre_crash", 64'(bus.night_rate), 64'd40);
      for (int i = 0; i < 10; i++) begin
         cycle(1, 1, 0, 0);
         cycle(0, 1, 0, 0);
      end
      check("crash_hold", 64'(bus.night_rate), 64'd40);
      cycle(1, 0, 0, 0);
      check("post_crash", 64'(bus.night_rate), 64'd42);

      // Restart mid-hold keeps stars
      qs(16);
      check("in_hold", 64'(bus.night_rate), 64'd63);
      saved = model_stars();
      cycle(0, 0, 1, 0);
      check("restart_rate", 64'(bus.night_rate), 64'd0);
      check("restart_night", 64'(bus.in_night), 64'd0);
      check("restart_stars", 64'(dut_stars()), 64'(saved));
      cycle(0, 0, 1, 1);
      qs(3);
      check("restart_trig_dropped", 64'(bus.night_rate), 64'd0);

      // Trigger during fade out is discarded
      cycle(0, 0, 0, 1);
      qs(32 + NF);
      check("fo_start", 64'(bus.night_rate), 64'd61);
      cycle(0, 0, 0, 1);
      qs(31);
      qs(5);
      check("fo_trig_ignored", 64'(bus.night_rate), 64'd0);
      check("fo_trig_night", 64'(bus.in_night), 64'd0);

      // Trigger under crash is latched
      cycle(0, 1, 0, 1);
      cycle(1, 1, 0, 0);
      check("crash_pend_frozen", 64'(bus.night_rate), 64'd0);
      cycle(1, 0, 0, 0);
      check("crash_pend_start", 64'(bus.night_rate), 64'd2);

      // Async reset mid-night
      qs(5);
      do_reset();
      qs(3);

      // Star fold boundaries against the LFSR model
      n = 0;
      while (m_lfsr[8:0] != 9'd400 && n < 5000) begin cycle(0, 0, 0, 0); n++; end
      check("find_400", 64'(n < 5000), 64'd1);
      cycle(1, 0, 0, 1);
      check("sx0_fold", 64'(bus.star_x_rand[0]), 64'd80);
      cycle(0, 0, 1, 0);
      n = 0;
      while (m_lfsr[15:7] != 9'd319 && n < 5000) begin cycle(0, 0, 0, 0); n++; end
      check("find_319", 64'(n < 5000), 64'd1);
      cycle(1, 0, 0, 1);
      check("sx1_nofold", 64'(bus.star_x_rand[1]), 64'd319);
      cycle(0, 0, 1, 0);

      // Many short nights
      for (int i = 0; i < 1000; i++) begin
         cycle(1, 0, 0, 1);
         check("sy_range", 64'(bus.star_y_rand[0] <= 10'd63 && bus.star_y_rand[1] <= 10'd63), 64'd1);
         cycle(0, 0, 1, 0);
      end

      // Random mix
      for (int i = 0; i < 2000; i++)
         cycle($urandom_range(0, 1), $urandom_range(0, 7) == 0,
               $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
